hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage WISC core. It drives the enables of the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers and the PC write enable. It keeps a destination-register scoreboard of in-flight instructions to stall on RAW hazards, since the datapath has no forwarding. It also squashes wrong-path instructions on a taken branch or jump, freezes the pipe while data memory is busy, and sequences halt drain.

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RAW scoreboard stalls, redirect squash, memory freeze, halt drain.
// Build option: define HAZARD_RF_BYPASS_EN when the register file bypasses writes to same-cycle reads.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [2:0]  dec_Rs,
  input  logic [2:0]  dec_Rt,
  input  logic        dec_useRs,
  input  logic        dec_useRt,
  input  logic        dec_writeEn,
  input  logic [2:0]  dec_writeRegSel,
  input  logic        dec_HaltPC,
  input  logic        exe_redirect,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ftchDecEn,
  output logic        decExeEn,
  output logic        exeMemEn,
  output logic        memWbEn,
  output logic        ftchDec_flush,
  output logic        decExe_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic        err
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  // Scoreboard slot 0 = EX, 1 = MEM, 2 = WB.
`ifdef HAZARD_RF_BYPASS_EN
  localparam logic [2:0] CMP_MASK = 3'b011;
`else
  localparam logic [2:0] CMP_MASK = 3'b111;
`endif

  state_t      state_reg, state_next;
  logic [2:0]  v_reg, v_next;
  logic [2:0]  dst_reg [3];
  logic [2:0]  dst_next [3];
  logic [1:0]  drain_cnt_reg, drain_cnt_next;
  logic [15:0] stall_cnt_reg, stall_cnt_next;
  logic        err_reg, err_next;

  logic [2:0]  hit_rs, hit_rt;
  logic        raw, advance, ex_load;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cmp
      assign hit_rs[gi] = v_reg[gi] && (dst_reg[gi] == dec_Rs);
      assign hit_rt[gi] = v_reg[gi] && (dst_reg[gi] == dec_Rt);
    end
  endgenerate

  assign raw = dec_valid && ((dec_useRs && |(hit_rs & CMP_MASK)) ||
                             (dec_useRt && |(hit_rt & CMP_MASK)));

  assign advance = (state_reg != S_HALTED) && !mem_busy;
  assign ex_load = dec_valid && dec_writeEn && !raw && !exe_redirect;

  // Enable, flush and bubble outputs.
  always_comb begin
    pc_en         = 1'b0;
    ftchDecEn     = 1'b0;
    decExeEn      = 1'b0;
    exeMemEn      = 1'b0;
    memWbEn       = 1'b0;
    ftchDec_flush = 1'b0;
    decExe_bubble = 1'b0;
    if (!rst) begin
      ftchDec_flush = 1'b1;
    end else if (state_reg != S_HALTED) begin
      if (mem_busy) begin
        pc_en = 1'b0;
      end else if (exe_redirect) begin
        {pc_en, ftchDecEn, decExeEn, exeMemEn, memWbEn} = 5'b11111;
        ftchDec_flush = 1'b1;
        decExe_bubble = 1'b1;
      end else if (raw) begin
        {decExeEn, exeMemEn, memWbEn} = 3'b111;
        decExe_bubble = 1'b1;
      end else begin
        {pc_en, ftchDecEn, decExeEn, exeMemEn, memWbEn} = 5'b11111;
      end
      // While draining, fetch is stopped and nothing new enters decode.
      if (state_reg == S_DRAIN) begin
        pc_en         = 1'b0;
        ftchDec_flush = 1'b1;
      end
    end
  end

  // Registered state: scoreboard, halt FSM, counters, sticky error.
  always_comb begin
    state_next     = state_reg;
    v_next         = v_reg;
    dst_next       = dst_reg;
    drain_cnt_next = drain_cnt_reg;
    stall_cnt_next = stall_cnt_reg;
    err_next       = err_reg;

    if (advance) begin
      v_next      = {v_reg[1:0], ex_load};
      dst_next[2] = dst_reg[1];
      dst_next[1] = dst_reg[0];
      dst_next[0] = dec_writeRegSel;
      if (raw && !exe_redirect && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_next = stall_cnt_reg + 16'd1;
    end

    unique case (state_reg)
      S_RUN: begin
        if (advance && !exe_redirect && !raw && dec_valid && dec_HaltPC) begin
          state_next     = S_DRAIN;
          drain_cnt_next = 2'd0;
        end
      end
      S_DRAIN: begin
        if (dec_valid && dec_HaltPC)
          err_next = 1'b1;
        if (advance) begin
          if (drain_cnt_reg == 2'(DRAIN_CYCLES - 1))
            state_next = S_HALTED;
          else
            drain_cnt_next = drain_cnt_reg + 2'd1;
        end
      end
      S_HALTED: begin
        if (exe_redirect)
          err_next = 1'b1;
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_RUN;
      v_reg         <= 3'b000;
      dst_reg       <= '{3'd0, 3'd0, 3'd0};
      drain_cnt_reg <= 2'd0;
      stall_cnt_reg <= 16'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      v_reg         <= v_next;
      dst_reg       <= dst_next;
      drain_cnt_reg <= drain_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign halted    = (state_reg == S_HALTED);
  assign stall_cnt = stall_cnt_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against an in-bench pipeline model.
module tb_hazard_ctrl;

  localparam int DC = 3;
`ifdef HAZARD_RF_BYPASS_EN
  localparam int NCMP   = 2;
  localparam int STALLS = 2;
`else
  localparam int NCMP   = 3;
  localparam int STALLS = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_valid = 0, dec_useRs = 0, dec_useRt = 0, dec_writeEn = 0, dec_HaltPC = 0;
  logic [2:0] dec_Rs = 0, dec_Rt = 0, dec_writeRegSel = 0;
  logic exe_redirect = 0, mem_busy = 0;
  logic pc_en, ftchDecEn, decExeEn, exeMemEn, memWbEn, ftchDec_flush, decExe_bubble, halted, err;
  logic [15:0] stall_cnt;

  hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_Rs(dec_Rs), .dec_Rt(dec_Rt),
    .dec_useRs(dec_useRs), .dec_useRt(dec_useRt), .dec_writeEn(dec_writeEn),
    .dec_writeRegSel(dec_writeRegSel), .dec_HaltPC(dec_HaltPC), .exe_redirect(exe_redirect),
    .mem_busy(mem_busy), .pc_en(pc_en), .ftchDecEn(ftchDecEn), .decExeEn(decExeEn),
    .exeMemEn(exeMemEn), .memWbEn(memWbEn), .ftchDec_flush(ftchDec_flush),
    .decExe_bubble(decExe_bubble), .halted(halted), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %0s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: in-flight destinations oldest-last, halt phase 0=run 1=drain 2=halted.
  bit         m_v [3];
  logic [2:0] m_d [3];
  int         m_phase, m_drain, m_stall;
  bit         m_err;

  logic [4:0] g_en;
  logic       g_flush, g_bub, g_halted;

  function automatic bit reads_inflight(input logic [2:0] r);
    for (int k = 0; k < NCMP; k++)
      if (m_v[k] && m_d[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_d[k] = 0; end
    m_phase = 0; m_drain = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #2;
    check("rst.en", {pc_en, ftchDecEn, decExeEn, exeMemEn, memWbEn}, 5'b00000);
    check("rst.flush", ftchDec_flush, 1'b1);
    check("rst.bub_halt_err", {decExe_bubble, halted, err}, 3'b000);
    check("rst.stall", stall_cnt, 16'd0);
    $display("reset asserted");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drive(input string tag, input logic v, input logic [2:0] rs, input logic urs,
                       input logic [2:0] rt, input logic urt, input logic we, input logic [2:0] ws,
                       input logic hlt, input logic rd, input logic bz);
    bit raw_e, adv;
    logic [4:0] e_en;
    logic e_flush, e_bub;
    dec_valid = v; dec_Rs = rs; dec_useRs = urs; dec_Rt = rt; dec_useRt = urt;
    dec_writeEn = we; dec_writeRegSel = ws; dec_HaltPC = hlt; exe_redirect = rd; mem_busy = bz;
    #2;
    raw_e = v && ((urs && reads_inflight(rs)) || (urt && reads_inflight(rt)));
    e_en = 5'b00000; e_flush = 0; e_bub = 0;
    if (m_phase != 2) begin
      if (bz) e_en = 5'b00000;
      else if (rd) begin e_en = 5'b11111; e_flush = 1; e_bub = 1; end
      else if (raw_e) begin e_en = 5'b00111; e_bub = 1; end
      else e_en = 5'b11111;
      if (m_phase == 1) begin e_en[4] = 1'b0; e_flush = 1; end
    end
    g_en = {pc_en, ftchDecEn, decExeEn, exeMemEn, memWbEn};
    g_flush = ftchDec_flush; g_bub = decExe_bubble; g_halted = halted;
    check({tag, ".en"}, g_en, e_en);
    check({tag, ".flush"}, g_flush, e_flush);
    check({tag, ".bubble"}, g_bub, e_bub);
    check({tag, ".halted"}, g_halted, m_phase == 2);
    check({tag, ".err"}, err, m_err);
    check({tag, ".stall_cnt"}, stall_cnt, m_stall);
    $display("%0s v=%0b rs=%0d/%0b rt=%0d/%0b w=%0b/%0d h=%0b rd=%0b bz=%0b en=%05b fl=%0b bb=%0b hl=%0b st=%0d",
             tag, v, rs, urs, rt, urt, we, ws, hlt, rd, bz, g_en, g_flush, g_bub, g_halted, stall_cnt);
    // Predict state after the edge.
    if (m_phase == 2 && rd) m_err = 1;
    if (m_phase == 1 && v && hlt) m_err = 1;
    adv = (m_phase != 2) && !bz;
    if (adv) begin
      m_v[2] = m_v[1]; m_d[2] = m_d[1];
      m_v[1] = m_v[0]; m_d[1] = m_d[0];
      m_v[0] = v && we && !raw_e && !rd; m_d[0] = ws;
      if (raw_e && !rd && m_stall < 65535) m_stall++;
      if (m_phase == 1) begin
        m_drain++;
        if (m_drain == DC) m_phase = 2;
      end else if (!rd && !raw_e && v && hlt) begin
        m_phase = 1; m_drain = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input string tag, input logic bz);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, bz);
  endtask

  initial begin
    int stalls_after;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back dependency.
    drive("dep.prod", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive("dep.cons", 1, 1, 1, 0, 0, 1, 2, 0, 0, 0);
      check("dep.pc_en", g_en[4], (i < STALLS) ? 1'b0 : 1'b1);
    end
    check("dep.stall_total", stall_cnt, STALLS);
    for (int i = 0; i < 3; i++) bubble("dep.idle", 0);

    // Independent sources.
    do_reset();
    drive("ind.prod", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive("ind.cons", 1, 2, 1, 3, 1, 1, 3, 0, 0, 0);
    check("ind.en", g_en, 5'b11111);
    check("ind.stall_total", stall_cnt, 0);

    // Taken branch while decode has a RAW.
    do_reset();
    drive("br.prod", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive("br.cons", 1, 1, 1, 0, 0, 1, 2, 0, 1, 0);
    check("br.flush_bub_pc", {g_flush, g_bub, g_en[4]}, 3'b111);
    check("br.stall_total", stall_cnt, 0);

    // Memory freeze in the middle of a stall.
    do_reset();
    drive("bz.prod", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive("bz.cons", 1, 1, 1, 0, 0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive("bz.frozen", 1, 1, 1, 0, 0, 1, 2, 0, 0, 1);
      check("bz.en", g_en, 5'b00000);
    end
    stalls_after = 0;
    for (int i = 0; i < 8; i++) begin
      drive("bz.resume", 1, 1, 1, 0, 0, 1, 2, 0, 0, 0);
      if (g_en[4]) break;
      stalls_after++;
    end
    check("bz.remaining", stalls_after, STALLS - 1);
    check("bz.stall_total", stall_cnt, STALLS);

    // Halt drain with an intervening memory freeze, then redirect while halted.
    do_reset();
    drive("halt.dec", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("halt.dec_en", g_en, 5'b11111);
    bubble("halt.drain", 0);
    check("halt.pc_off", {g_en[4], g_flush}, 2'b01);
    bubble("halt.busy", 1);
    check("halt.not_yet", g_halted, 1'b0);
    for (int i = 1; i < DC; i++) bubble("halt.drain", 0);
    check("halt.halted", halted, 1'b1);
    bubble("halt.stopped", 0);
    check("halt.en_off", g_en, 5'b00000);
    drive("halt.redir", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("halt.err", err, 1'b1);

    // Reset in the middle of a drain leaves no trace.
    do_reset();
    drive("rd.prod", 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    drive("rd.halt", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    bubble("rd.drain", 0);
    do_reset();
    check("rd.halted", halted, 1'b0);
    drive("rd.cons", 1, 4, 1, 0, 0, 1, 5, 0, 0, 0);
    check("rd.en", {g_en, g_flush}, 6'b111110);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ((m_phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
      drive("rnd", $urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 1'($urandom),
            3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
            $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
